// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared pipeline types: memory-stage FSM states, writeback selects.
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC4 = 2'd2;
    localparam logic [1:0] c_WB_IMM = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module  : mem_stage
// Brief   : Pipeline memory stage: data-memory handshake, timeout abort and
//           MEM/WB pipeline register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_Alu_Result,
    input  logic [31:0] EX_Pc4,
    input  logic [31:0] EX_Imm,
    input  logic [31:0] EX_Wdata,
    input  logic [4:0]  EX_RegD,
    input  logic [1:0]  EX_WBsel,
    input  logic        EX_WReg,
    input  logic        EX_Rmem,
    input  logic        EX_Wmem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        MEM_Stall,
    output logic [31:0] MEM_Alu_Result,
    output logic [31:0] MEM_Rdata,
    output logic [31:0] MEM_Pc4,
    output logic [31:0] MEM_Imm,
    output logic [4:0]  MEM_RegD,
    output logic [1:0]  MEM_WBsel,
    output logic        MEM_WReg,
    output logic        MEM_Err
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_TMO = CNT_W'(TIMEOUT);

    mem_state_e       r_state;
    mem_state_e       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_mem_op;
    logic             w_legal;
    logic             w_illegal;
    logic             w_req;
    logic             w_stall;
    logic             w_err;
    logic             w_load_done;

    assign w_mem_op  = EX_Rmem | EX_Wmem;
    assign w_legal   = w_mem_op && (EX_Alu_Result[1:0] == 2'b00) && !(EX_Rmem && EX_Wmem);
    assign w_illegal = w_mem_op && !w_legal;
    assign w_cnt_inc = (r_cnt == c_TMO) ? r_cnt : r_cnt + CNT_W'(1);

    // Reset forces every combinational output to idle, overriding any pending op.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_err        = 1'b0;
        w_load_done  = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        if (r_cnt == c_TMO) begin
                            w_err      = 1'b1;
                            w_next_cnt = '0;
                        end else begin
                            w_req = 1'b1;
                            if (dmem_ready) begin
                                w_next_cnt = '0;
                                if (EX_Rmem) begin
                                    w_stall      = 1'b1;
                                    w_next_state = WAIT;
                                end
                            end else begin
                                w_stall    = 1'b1;
                                w_next_cnt = w_cnt_inc;
                            end
                        end
                    end else begin
                        w_err      = w_illegal;
                        w_next_cnt = '0;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        w_load_done  = 1'b1;
                        w_next_state = IDLE;
                        w_next_cnt   = '0;
                    end else if (r_cnt == c_TMO) begin
                        w_err        = 1'b1;
                        w_next_state = IDLE;
                        w_next_cnt   = '0;
                    end else begin
                        w_stall    = 1'b1;
                        w_next_cnt = w_cnt_inc;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    assign dmem_req   = w_req;
    assign dmem_we    = w_req & EX_Wmem;
    assign dmem_addr  = EX_Alu_Result;
    assign dmem_wdata = EX_Wdata;
    assign MEM_Stall  = w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            MEM_Alu_Result <= '0;
            MEM_Rdata      <= '0;
            MEM_Pc4        <= '0;
            MEM_Imm        <= '0;
            MEM_RegD       <= '0;
            MEM_WBsel      <= '0;
            MEM_WReg       <= 1'b0;
            MEM_Err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_stall) begin
                MEM_Alu_Result <= '0;
                MEM_Rdata      <= '0;
                MEM_Pc4        <= '0;
                MEM_Imm        <= '0;
                MEM_RegD       <= '0;
                MEM_WBsel      <= '0;
                MEM_WReg       <= 1'b0;
                MEM_Err        <= 1'b0;
            end else begin
                MEM_Alu_Result <= EX_Alu_Result;
                MEM_Rdata      <= w_load_done ? dmem_rdata : 32'd0;
                MEM_Pc4        <= EX_Pc4;
                MEM_Imm        <= EX_Imm;
                MEM_RegD       <= EX_RegD;
                MEM_WBsel      <= EX_WBsel;
                MEM_WReg       <= EX_WReg & ~w_err;
                MEM_Err        <= w_err;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles a data-memory access may stay outstanding before abort.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 EX_Alu_Result  in  32  effective address / ALU result.
REQ-005 EX_Pc4, EX_Imm, EX_Wdata  in  32 each  PC+4, immediate, store data.
REQ-006 EX_RegD  in  5; EX_WBsel  in  2; EX_WReg, EX_Rmem, EX_Wmem  in  1 each  destination reg, writeback select, regwrite/load/store flags.
REQ-007 dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  32  memory request channel.
REQ-008 dmem_ready  in  1  request accepted when dmem_req & dmem_ready.
REQ-009 dmem_rvalid  in  1; dmem_rdata  in  32  load response.
REQ-010 MEM_Stall  out  1  upstream SHALL hold all EX_* inputs stable while high.
REQ-011 MEM_Alu_Result, MEM_Rdata, MEM_Pc4, MEM_Imm  out  32 (registered).
REQ-012 MEM_RegD  out  5; MEM_WBsel  out  2; MEM_WReg, MEM_Err  out  1 (registered).

Function
REQ-013 Memory op = EX_Rmem | EX_Wmem; no op = pass-through, MEM_Stall=0, MEM/WB register loads every cycle.
REQ-014 FSM states IDLE, WAIT; IDLE covers request phase, WAIT awaits load data.
REQ-015 Legal op (aligned EX_Alu_Result[1:0]==0, not both Rmem and Wmem) in IDLE: dmem_req=1, dmem_we=EX_Wmem, dmem_addr=EX_Alu_Result, dmem_wdata=EX_Wdata, held until accepted.
REQ-016 Store accepted: MEM_Stall=0 that cycle, MEM/WB register captures, stay IDLE (single-cycle store when dmem_ready already high).
REQ-017 Load accepted: MEM_Stall=1, go WAIT; dmem_req=0 in WAIT.
REQ-018 WAIT: dmem_rvalid sampled only here (earliest one cycle after acceptance); on rvalid MEM_Stall=0, MEM_Rdata<=dmem_rdata, capture, go IDLE.
REQ-019 dmem_rvalid in IDLE SHALL be ignored.
REQ-020 MEM_Stall=1 whenever a legal op is pending and not completing this cycle.
REQ-021 While MEM_Stall=1, MEM/WB register loads a bubble: MEM_WReg=0, MEM_Err=0.
REQ-022 MEM_Rdata=0 for any non-load capture.
REQ-023 Illegal op (misaligned or Rmem&Wmem): no request, MEM_Stall=0, capture with MEM_WReg forced 0, MEM_Err=1 for one cycle.
REQ-024 Timeout counter clears on each new request/acceptance, increments each stalled cycle; reaching TIMEOUT aborts: dmem_req dropped, go IDLE, MEM_Stall=0, capture with MEM_WReg=0, MEM_Err=1.
REQ-025 Counter width $clog2(TIMEOUT+1), saturating, never wraps.
REQ-026 MEM_Err high for exactly one cycle per failing instruction.

Reset
REQ-027 rst SHALL take precedence over all events, including mid-WAIT and mid-request.
REQ-028 Reset values: state IDLE, counter 0, all MEM_* outputs 0.
REQ-029 dmem_req, dmem_we, MEM_Stall SHALL be 0 while rst is high; responses arriving after reset are dropped per REQ-019.

Structure
REQ-030 Shared package riscv_pkg holds state enum (IDLE, WAIT) and WBsel encodings, shared with ex and writeback.
REQ-031 No sub-module; FSM, timeout counter, and MEM/WB register are inline.

Verification
REQ-032 ALU op, EX_Alu_Result=0x1234, WReg=1, RegD=5 -> next cycle MEM_Alu_Result=0x1234, MEM_RegD=5, MEM_WReg=1, no dmem_req.
REQ-033 Store addr 0x100, data 0xDEADBEEF, dmem_ready=1 -> one-cycle req with we=1, MEM_Stall never high.
REQ-034 Load addr 0x200, ready after 2 cycles, rvalid 3 cycles later with 0xCAFEF00D -> MEM_Stall high 5 cycles, then MEM_Rdata=0xCAFEF00D, MEM_WReg=1.
REQ-035 Load addr 0x202 -> no request, MEM_Err one-cycle pulse, MEM_WReg=0.
REQ-036 TIMEOUT=4, load never answered -> abort after 4 stalled cycles, MEM_Err pulse, back to IDLE.
REQ-037 rst asserted in WAIT, rvalid arrives next cycle -> outputs 0, rvalid ignored, dmem_req=0.
